// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings,
// the default boot address, next-PC op encodings used by the downstream
// next-PC logic, and small PC helper functions.
package if_fetch_stage_pkg;

    // Fetch-stage control states.
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    // First fetch address after reset unless the instance overrides it.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Next-PC op encodings shared with the next-PC logic.
    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_JAL    = 2'd1,
        NPC_JALR   = 2'd2,
        NPC_BRANCH = 2'd3
    } npc_op_t;

    // Sequential successor of a fetch address; wraps naturally at 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO used twice by the fetch stage: once to remember
// the addresses of outstanding memory requests, once to buffer returned
// {pc, instr} pairs for decode. The head (dout) is combinational from
// storage. A push while full is only accepted when a pop happens in the
// same cycle. clr empties the FIFO without touching storage.
module if_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer, count and storage update; storage is zeroed on reset so
    // the head reads as zero before the first push.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. Owns the fetch PC, issues word-aligned requests
// to instruction memory, pairs each in-order response with the address it
// was fetched from, and presents the oldest {pc, instr} to decode. A
// redirect from the next-PC logic retargets the fetch PC, empties the
// decode buffer and marks every in-flight response as wrong-path.
//
// Handshakes:
//   imem: a request transfers on imem_req_o && imem_gnt_i; imem_addr_o is
//         held while req is up and gnt is low. Responses arrive in order,
//         one per imem_rvalid_i pulse, with no backpressure.
//   decode: the head transfers on if_valid_o && id_ready_i. if_valid_o does
//         not depend on id_ready_i, and the head stays put until taken.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [31:0]  npc_i,
    input  logic         redirect_i,
    output logic         imem_req_o,
    output logic [31:0]  imem_addr_o,
    input  logic         imem_gnt_i,
    input  logic         imem_rvalid_i,
    input  logic [31:0]  imem_rdata_i,
    output logic         if_valid_o,
    output logic [31:0]  if_instr_o,
    output logic [31:0]  if_pc_o,
    input  logic         id_ready_i,
    output fetch_state_t dbg_state
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] discard;

    // Address queue: its occupancy is the outstanding-request count.
    logic [31:0]   aq_head;
    logic          aq_full;
    logic          aq_empty;
    logic [CW-1:0] outstanding;

    // Decode buffer of {pc, instr}.
    logic [63:0]   buf_head;
    logic          buf_full;
    logic          buf_empty;
    logic [CW-1:0] occupancy;

    logic [CW:0]   inflight;
    logic          fire;
    logic          rsp_ok;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          dec_pop;
    logic [CW-1:0] redir_discard;

    // Requests plus buffered instructions may never exceed the buffer, so
    // every response has a slot waiting for it. The full flags are
    // implied by the sum but keep the guard local to each queue.
    assign inflight   = {1'b0, outstanding} + {1'b0, occupancy};
    assign imem_req_o = (state == S_FETCH) && !redirect_i &&
                        (inflight < DEPTH_W) && !aq_full && !buf_full;
    assign imem_addr_o = fetch_pc;
    assign fire        = imem_req_o && imem_gnt_i;

    // A response with nothing outstanding is a protocol error and is
    // ignored (for example a stray beat just after reset).
    assign rsp_ok   = imem_rvalid_i && !aq_empty;
    assign rsp_drop = rsp_ok && (discard != '0);
    assign rsp_keep = rsp_ok && (discard == '0) && !redirect_i;

    assign if_valid_o = !buf_empty;
    assign if_pc_o    = buf_head[63:32];
    assign if_instr_o = buf_head[31:0];
    assign dec_pop    = if_valid_o && id_ready_i;

    // On a redirect every response still in flight after this cycle is
    // wrong-path. Responses already marked for discard are part of the
    // outstanding count, so the new discard count is simply what remains
    // outstanding once this cycle's response (if any) has been consumed.
    // No grant can coincide because req is held low during a redirect.
    assign redir_discard = outstanding - CW'(rsp_ok);

    assign dbg_state = state;

    if_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_addr_q (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (1'b0),
        .push  (fire),
        .din   (fetch_pc),
        .pop   (rsp_ok),
        .dout  (aq_head),
        .full  (aq_full),
        .empty (aq_empty),
        .count (outstanding)
    );

    if_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (redirect_i),
        .push  (rsp_keep),
        .din   ({aq_head, imem_rdata_i}),
        .pop   (dec_pop),
        .dout  (buf_head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (occupancy)
    );

    // Fetch control FSM: fetch PC, discard counter and state. Redirect
    // takes priority over every other update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_BOOT;
            fetch_pc <= RESET_PC;
            discard  <= '0;
        end else if (redirect_i) begin
            fetch_pc <= word_align(npc_i);
            discard  <= redir_discard;
            state    <= (redir_discard != '0) ? S_DRAIN : S_FETCH;
        end else begin
            if (fire) begin
                fetch_pc <= pc_plus4(fetch_pc);
            end
            if (rsp_drop) begin
                discard <= discard - CW'(1);
            end
            case (state)
                S_BOOT:  state <= S_FETCH;
                S_FETCH: state <= S_FETCH;
                S_DRAIN: if (discard == '0) state <= S_FETCH;
                default: state <= S_BOOT;
            endcase
        end
    end

endmodule
